// File: rtl/cache_bank_router.sv
// cache_bank_router: steers execute lookups to BANK_NUM cache banks, merges bank
// results and bank misses through registered round-robin stages, tags misses
// with their bank id toward module A, routes responses back by that id, and
// throttles each bank to MAX_OUTSTANDING unanswered misses.
module cache_bank_router #(
  parameter int BANK_NUM        = 4,
  parameter int INFO_LENGTH     = 20,
  parameter int ORDER_ID        = 3,
  parameter int REGISTER_NUM    = 320,
  parameter int ROB_NUM         = 128,
  parameter int REQ_WIDTH       = 10,
  parameter int MAX_OUTSTANDING = 8,
  localparam int BW  = $clog2(BANK_NUM),
  localparam int RW  = $clog2(REGISTER_NUM),
  localparam int OW  = $clog2(ROB_NUM),
  localparam int CW  = $clog2(MAX_OUTSTANDING + 1),
  localparam int BIL = INFO_LENGTH - BW,
  localparam int BRQ = REQ_WIDTH - BW
) (
  input  logic                          clk,
  input  logic                          rst,
  // request from execute
  input  logic                          table_ex_valid_i,
  output logic                          table_ex_ready_i,
  input  logic [INFO_LENGTH-1:0]        table_ex_info_i,
  input  logic [ORDER_ID-1:0]           table_ex_id_i,
  input  logic                          table_ex_so_i,
  input  logic [RW-1:0]                 table_ex_data_entry_i,
  input  logic [OW-1:0]                 table_ex_rob_entry_i,
  // result to execute
  output logic                          table_ex_valid_o,
  input  logic                          table_ex_ready_o,
  output logic [INFO_LENGTH-1:0]        table_ex_info_o,
  output logic [ORDER_ID-1:0]           table_ex_id_o,
  output logic                          table_ex_so_o,
  output logic [RW-1:0]                 table_ex_data_entry_o,
  output logic [OW-1:0]                 table_ex_rob_entry_o,
  // miss path to module A
  output logic                          c2a_lkp_vld,
  input  logic                          a2c_lkp_rdy,
  output logic [INFO_LENGTH-1:0]        c2a_lkp_info,
  output logic [REQ_WIDTH-1:0]          c2a_lkp_req_id,
  input  logic                          a2c_lkp_rsp_vld,
  input  logic [REQ_WIDTH-1:0]          a2c_lkp_rsp_id,
  input  logic [INFO_LENGTH-1:0]        a2c_lkp_rslt,
  // bank request side
  output logic [BANK_NUM-1:0]           bk_in_valid,
  input  logic [BANK_NUM-1:0]           bk_in_ready,
  output logic [BIL-1:0]                bk_in_info,
  output logic [ORDER_ID-1:0]           bk_in_id,
  output logic                          bk_in_so,
  output logic [RW-1:0]                 bk_in_data_entry,
  output logic [OW-1:0]                 bk_in_rob_entry,
  // bank result side
  input  logic [BANK_NUM-1:0]           bk_out_valid,
  output logic [BANK_NUM-1:0]           bk_out_ready,
  input  logic [BANK_NUM*INFO_LENGTH-1:0] bk_out_info,
  input  logic [BANK_NUM*ORDER_ID-1:0]  bk_out_id,
  input  logic [BANK_NUM-1:0]           bk_out_so,
  input  logic [BANK_NUM*RW-1:0]        bk_out_data_entry,
  input  logic [BANK_NUM*OW-1:0]        bk_out_rob_entry,
  // bank miss side
  input  logic [BANK_NUM-1:0]           bk_c2a_vld,
  output logic [BANK_NUM-1:0]           bk_c2a_rdy,
  input  logic [BANK_NUM*BIL-1:0]       bk_c2a_info,
  input  logic [BANK_NUM*BRQ-1:0]       bk_c2a_req_id,
  // bank response side
  output logic [BANK_NUM-1:0]           bk_rsp_vld,
  output logic [BRQ-1:0]                bk_rsp_id,
  output logic [INFO_LENGTH-1:0]        bk_rslt,
  output logic                          rsp_err_o
);

  // Round-robin pick: search starts just after ptr and wraps; MSB flags a hit.
  function automatic logic [BW:0] rr_pick(input logic [BANK_NUM-1:0] req,
                                          input logic [BW-1:0] ptr);
    logic [BW:0]   pick;
    logic [BW-1:0] cand;
    pick = '0;
    for (int i = 1; i <= BANK_NUM; i++) begin
      cand = ptr + BW'(i);
      if (!pick[BW] && req[cand]) begin
        pick = {1'b1, cand};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Unpacked views of the packed per-bank buses
  logic [INFO_LENGTH-1:0] out_info_a [BANK_NUM];
  logic [ORDER_ID-1:0]    out_id_a   [BANK_NUM];
  logic [RW-1:0]          out_de_a   [BANK_NUM];
  logic [OW-1:0]          out_re_a   [BANK_NUM];
  logic [BIL-1:0]         c2a_info_a [BANK_NUM];
  logic [BRQ-1:0]         c2a_req_a  [BANK_NUM];

  for (genvar g = 0; g < BANK_NUM; g++) begin : g_unpack
    assign out_info_a[g] = bk_out_info[g*INFO_LENGTH +: INFO_LENGTH];
    assign out_id_a[g]   = bk_out_id[g*ORDER_ID +: ORDER_ID];
    assign out_de_a[g]   = bk_out_data_entry[g*RW +: RW];
    assign out_re_a[g]   = bk_out_rob_entry[g*OW +: OW];
    assign c2a_info_a[g] = bk_c2a_info[g*BIL +: BIL];
    assign c2a_req_a[g]  = bk_c2a_req_id[g*BRQ +: BRQ];
  end

  // ---------------- request steering (combinational) ----------------
  logic [BW-1:0] sel_s;
  assign sel_s = table_ex_info_i[BW-1:0];

  // Route the request valid to the selected bank only
  always_comb begin
    bk_in_valid        = '0;
    bk_in_valid[sel_s] = table_ex_valid_i;
  end

  assign table_ex_ready_i = bk_in_ready[sel_s];
  assign bk_in_info       = table_ex_info_i[INFO_LENGTH-1:BW];
  assign bk_in_id         = table_ex_id_i;
  assign bk_in_so         = table_ex_so_i;
  assign bk_in_data_entry = table_ex_data_entry_i;
  assign bk_in_rob_entry  = table_ex_rob_entry_i;

  // ---------------- result merge ----------------
  logic                   res_valid_q, res_valid_d;
  logic [INFO_LENGTH-1:0] res_info_q, res_info_d;
  logic [ORDER_ID-1:0]    res_id_q, res_id_d;
  logic                   res_so_q, res_so_d;
  logic [RW-1:0]          res_de_q, res_de_d;
  logic [OW-1:0]          res_re_q, res_re_d;
  logic [BW-1:0]          res_ptr_q, res_ptr_d;
  logic                   res_load_s, res_gnt_s;
  logic [BW:0]            res_pick_s;
  logic [BW-1:0]          res_idx_s;

  assign res_load_s = !res_valid_q || table_ex_ready_o;
  assign res_pick_s = rr_pick(bk_out_valid, res_ptr_q);
  assign res_gnt_s  = res_load_s && res_pick_s[BW];
  assign res_idx_s  = res_pick_s[BW-1:0];

  // One-hot ready back to the granted result bank
  always_comb begin
    bk_out_ready = '0;
    if (res_gnt_s) begin
      bk_out_ready[res_idx_s] = 1'b1;
    end else begin
      bk_out_ready = '0;
    end
  end

  // Result register next state: capture on grant, drain when consumed
  always_comb begin
    res_valid_d = res_valid_q;
    res_info_d  = res_info_q;
    res_id_d    = res_id_q;
    res_so_d    = res_so_q;
    res_de_d    = res_de_q;
    res_re_d    = res_re_q;
    res_ptr_d   = res_ptr_q;
    if (res_gnt_s) begin
      res_valid_d = 1'b1;
      res_info_d  = out_info_a[res_idx_s];
      res_id_d    = out_id_a[res_idx_s];
      res_so_d    = bk_out_so[res_idx_s];
      res_de_d    = out_de_a[res_idx_s];
      res_re_d    = out_re_a[res_idx_s];
      res_ptr_d   = res_idx_s;
    end else if (table_ex_ready_o) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // Result register state; pointer resets to the last bank so bank 0 wins first
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_info_q  <= '0;
      res_id_q    <= '0;
      res_so_q    <= 1'b0;
      res_de_q    <= '0;
      res_re_q    <= '0;
      res_ptr_q   <= {BW{1'b1}};
    end else begin
      res_valid_q <= res_valid_d;
      res_info_q  <= res_info_d;
      res_id_q    <= res_id_d;
      res_so_q    <= res_so_d;
      res_de_q    <= res_de_d;
      res_re_q    <= res_re_d;
      res_ptr_q   <= res_ptr_d;
    end
  end

  assign table_ex_valid_o      = res_valid_q;
  assign table_ex_info_o       = res_info_q;
  assign table_ex_id_o         = res_id_q;
  assign table_ex_so_o         = res_so_q;
  assign table_ex_data_entry_o = res_de_q;
  assign table_ex_rob_entry_o  = res_re_q;

  // ---------------- miss merge toward module A ----------------
  logic [CW-1:0]          cnt_q [BANK_NUM];
  logic [CW-1:0]          cnt_d [BANK_NUM];
  logic                   err_q, err_d;
  logic                   c2a_vld_q, c2a_vld_d;
  logic [INFO_LENGTH-1:0] c2a_info_q, c2a_info_d;
  logic [REQ_WIDTH-1:0]   c2a_req_q, c2a_req_d;
  logic [BW-1:0]          c2a_ptr_q, c2a_ptr_d;
  logic [BANK_NUM-1:0]    c2a_elig_s, inc_s, dec_s;
  logic                   c2a_load_s, c2a_gnt_s;
  logic [BW:0]            c2a_pick_s;
  logic [BW-1:0]          c2a_idx_s;

  for (genvar g = 0; g < BANK_NUM; g++) begin : g_bank
    // a bank at its outstanding limit is simply not offered to the arbiter
    assign c2a_elig_s[g] = bk_c2a_vld[g] && (cnt_q[g] < CW'(MAX_OUTSTANDING));
    assign inc_s[g]      = c2a_gnt_s && (c2a_idx_s == BW'(g));
    assign dec_s[g]      = a2c_lkp_rsp_vld && (a2c_lkp_rsp_id[BW-1:0] == BW'(g));
  end

  assign c2a_load_s = !c2a_vld_q || a2c_lkp_rdy;
  assign c2a_pick_s = rr_pick(c2a_elig_s, c2a_ptr_q);
  assign c2a_gnt_s  = c2a_load_s && c2a_pick_s[BW];
  assign c2a_idx_s  = c2a_pick_s[BW-1:0];
  assign bk_c2a_rdy = inc_s;

  // Miss register next state: capture with bank id appended to info and req_id
  always_comb begin
    c2a_vld_d  = c2a_vld_q;
    c2a_info_d = c2a_info_q;
    c2a_req_d  = c2a_req_q;
    c2a_ptr_d  = c2a_ptr_q;
    if (c2a_gnt_s) begin
      c2a_vld_d  = 1'b1;
      c2a_info_d = {c2a_info_a[c2a_idx_s], c2a_idx_s};
      c2a_req_d  = {c2a_req_a[c2a_idx_s], c2a_idx_s};
      c2a_ptr_d  = c2a_idx_s;
    end else if (a2c_lkp_rdy) begin
      c2a_vld_d = 1'b0;
    end else begin
      c2a_vld_d = c2a_vld_q;
    end
  end

  // Outstanding counters: a same-cycle issue and response cancel out;
  // a response to an idle bank leaves it at zero and flags a sticky error
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int b = 0; b < BANK_NUM; b++) begin
      if (inc_s[b] && !dec_s[b]) begin
        cnt_d[b] = cnt_q[b] + CW'(1);
      end else if (dec_s[b] && !inc_s[b]) begin
        if (cnt_q[b] == CW'(0)) begin
          err_d = 1'b1;
        end else begin
          cnt_d[b] = cnt_q[b] - CW'(1);
        end
      end else begin
        cnt_d[b] = cnt_q[b];
      end
    end
  end

  // Miss register, counters and error flag state
  always_ff @(posedge clk) begin
    if (rst) begin
      c2a_vld_q  <= 1'b0;
      c2a_info_q <= '0;
      c2a_req_q  <= '0;
      c2a_ptr_q  <= {BW{1'b1}};
      err_q      <= 1'b0;
      for (int b = 0; b < BANK_NUM; b++) begin
        cnt_q[b] <= '0;
      end
    end else begin
      c2a_vld_q  <= c2a_vld_d;
      c2a_info_q <= c2a_info_d;
      c2a_req_q  <= c2a_req_d;
      c2a_ptr_q  <= c2a_ptr_d;
      err_q      <= err_d;
      for (int b = 0; b < BANK_NUM; b++) begin
        cnt_q[b] <= cnt_d[b];
      end
    end
  end

  assign c2a_lkp_vld    = c2a_vld_q;
  assign c2a_lkp_info   = c2a_info_q;
  assign c2a_lkp_req_id = c2a_req_q;
  assign rsp_err_o      = err_q;

  // ---------------- response demux (combinational) ----------------
  assign bk_rsp_vld = dec_s;
  assign bk_rsp_id  = a2c_lkp_rsp_id[REQ_WIDTH-1:BW];
  assign bk_rslt    = a2c_lkp_rslt;

endmodule

// File: tb/tb_cache_bank_router.sv
// Self-checking bench for cache_bank_router: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_cache_bank_router;
  localparam int N = 4, BW = 2, IL = 20, OI = 3, RW = 9, OW = 7, RQ = 10, MO = 8;
  localparam int BIL = IL - BW, BRQ = RQ - BW;

  logic clk = 1'b0;
  logic rst;
  logic          table_ex_valid_i, table_ex_ready_i, table_ex_so_i;
  logic [IL-1:0] table_ex_info_i;
  logic [OI-1:0] table_ex_id_i;
  logic [RW-1:0] table_ex_data_entry_i;
  logic [OW-1:0] table_ex_rob_entry_i;
  logic          table_ex_valid_o, table_ex_ready_o, table_ex_so_o;
  logic [IL-1:0] table_ex_info_o;
  logic [OI-1:0] table_ex_id_o;
  logic [RW-1:0] table_ex_data_entry_o;
  logic [OW-1:0] table_ex_rob_entry_o;
  logic          c2a_lkp_vld, a2c_lkp_rdy, a2c_lkp_rsp_vld, rsp_err_o;
  logic [IL-1:0] c2a_lkp_info, a2c_lkp_rslt, bk_rslt;
  logic [RQ-1:0] c2a_lkp_req_id, a2c_lkp_rsp_id;
  logic [N-1:0]  bk_in_valid, bk_in_ready, bk_out_valid, bk_out_ready, bk_out_so;
  logic [N-1:0]  bk_c2a_vld, bk_c2a_rdy, bk_rsp_vld;
  logic [BIL-1:0] bk_in_info;
  logic [OI-1:0] bk_in_id;
  logic          bk_in_so;
  logic [RW-1:0] bk_in_data_entry;
  logic [OW-1:0] bk_in_rob_entry;
  logic [N*IL-1:0]  bk_out_info;
  logic [N*OI-1:0]  bk_out_id;
  logic [N*RW-1:0]  bk_out_data_entry;
  logic [N*OW-1:0]  bk_out_rob_entry;
  logic [N*BIL-1:0] bk_c2a_info;
  logic [N*BRQ-1:0] bk_c2a_req_id;
  logic [BRQ-1:0]   bk_rsp_id;

  always #5 clk = ~clk;

  cache_bank_router dut (
    .clk(clk), .rst(rst),
    .table_ex_valid_i(table_ex_valid_i), .table_ex_ready_i(table_ex_ready_i),
    .table_ex_info_i(table_ex_info_i), .table_ex_id_i(table_ex_id_i),
    .table_ex_so_i(table_ex_so_i), .table_ex_data_entry_i(table_ex_data_entry_i),
    .table_ex_rob_entry_i(table_ex_rob_entry_i),
    .table_ex_valid_o(table_ex_valid_o), .table_ex_ready_o(table_ex_ready_o),
    .table_ex_info_o(table_ex_info_o), .table_ex_id_o(table_ex_id_o),
    .table_ex_so_o(table_ex_so_o), .table_ex_data_entry_o(table_ex_data_entry_o),
    .table_ex_rob_entry_o(table_ex_rob_entry_o),
    .c2a_lkp_vld(c2a_lkp_vld), .a2c_lkp_rdy(a2c_lkp_rdy),
    .c2a_lkp_info(c2a_lkp_info), .c2a_lkp_req_id(c2a_lkp_req_id),
    .a2c_lkp_rsp_vld(a2c_lkp_rsp_vld), .a2c_lkp_rsp_id(a2c_lkp_rsp_id),
    .a2c_lkp_rslt(a2c_lkp_rslt),
    .bk_in_valid(bk_in_valid), .bk_in_ready(bk_in_ready), .bk_in_info(bk_in_info),
    .bk_in_id(bk_in_id), .bk_in_so(bk_in_so), .bk_in_data_entry(bk_in_data_entry),
    .bk_in_rob_entry(bk_in_rob_entry),
    .bk_out_valid(bk_out_valid), .bk_out_ready(bk_out_ready), .bk_out_info(bk_out_info),
    .bk_out_id(bk_out_id), .bk_out_so(bk_out_so), .bk_out_data_entry(bk_out_data_entry),
    .bk_out_rob_entry(bk_out_rob_entry),
    .bk_c2a_vld(bk_c2a_vld), .bk_c2a_rdy(bk_c2a_rdy), .bk_c2a_info(bk_c2a_info),
    .bk_c2a_req_id(bk_c2a_req_id),
    .bk_rsp_vld(bk_rsp_vld), .bk_rsp_id(bk_rsp_id), .bk_rslt(bk_rslt),
    .rsp_err_o(rsp_err_o)
  );

  int check_cnt = 0;
  int err_cnt   = 0;

  // Count one comparison and report it if it mismatches
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  int            m_rptr, m_cptr;
  bit            m_vo, m_so, m_cv, m_err;
  logic [IL-1:0] m_info, m_cinfo;
  logic [OI-1:0] m_id;
  logic [RW-1:0] m_de;
  logic [OW-1:0] m_re;
  logic [RQ-1:0] m_creq;
  int            m_cnt [N];

  task automatic model_reset();
    m_rptr = N - 1; m_cptr = N - 1;
    m_vo = 1'b0; m_so = 1'b0; m_cv = 1'b0; m_err = 1'b0;
    m_info = '0; m_cinfo = '0; m_id = '0; m_de = '0; m_re = '0; m_creq = '0;
    for (int b = 0; b < N; b++) m_cnt[b] = 0;
  endtask

  // First requester after ptr, wrapping; -1 if none
  function automatic int rr(input logic [N-1:0] req, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (req[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    table_ex_valid_i = 1'b0; table_ex_info_i = '0; table_ex_id_i = '0; table_ex_so_i = 1'b0;
    table_ex_data_entry_i = '0; table_ex_rob_entry_i = '0; table_ex_ready_o = 1'b0;
    a2c_lkp_rdy = 1'b0; a2c_lkp_rsp_vld = 1'b0; a2c_lkp_rsp_id = '0; a2c_lkp_rslt = '0;
    bk_in_ready = '0; bk_out_valid = '0; bk_out_info = '0; bk_out_id = '0; bk_out_so = '0;
    bk_out_data_entry = '0; bk_out_rob_entry = '0; bk_c2a_vld = '0; bk_c2a_info = '0;
    bk_c2a_req_id = '0;
  endtask

  task automatic rand_data();
    table_ex_info_i = IL'($urandom); table_ex_id_i = OI'($urandom); table_ex_so_i = 1'($urandom);
    table_ex_data_entry_i = RW'($urandom); table_ex_rob_entry_i = OW'($urandom);
    a2c_lkp_rslt = IL'($urandom); bk_out_so = N'($urandom);
    for (int b = 0; b < N; b++) begin
      bk_out_info[b*IL +: IL]         = IL'($urandom);
      bk_out_id[b*OI +: OI]           = OI'($urandom);
      bk_out_data_entry[b*RW +: RW]   = RW'($urandom);
      bk_out_rob_entry[b*OW +: OW]    = OW'($urandom);
      bk_c2a_info[b*BIL +: BIL]       = BIL'($urandom);
      bk_c2a_req_id[b*BRQ +: BRQ]     = BRQ'($urandom);
    end
  endtask

  // Compare every output against the model, then advance the model one clock
  task automatic step();
    int sel, rg, cg, rb;
    logic [N-1:0] elig;
    #1;
    sel = table_ex_info_i % N;
    check("bk_in_valid", bk_in_valid, table_ex_valid_i ? (64'd1 << sel) : 64'd0);
    check("ready_i", table_ex_ready_i, bk_in_ready[sel]);
    check("bk_in_info", bk_in_info, table_ex_info_i >> BW);
    check("bk_in_side", {bk_in_id, bk_in_so, bk_in_data_entry, bk_in_rob_entry},
          {table_ex_id_i, table_ex_so_i, table_ex_data_entry_i, table_ex_rob_entry_i});
    rg = (!m_vo || table_ex_ready_o) ? rr(bk_out_valid, m_rptr) : -1;
    check("bk_out_ready", bk_out_ready, (rg >= 0) ? (64'd1 << rg) : 64'd0);
    for (int b = 0; b < N; b++) elig[b] = bk_c2a_vld[b] && (m_cnt[b] < MO);
    cg = (!m_cv || a2c_lkp_rdy) ? rr(elig, m_cptr) : -1;
    check("bk_c2a_rdy", bk_c2a_rdy, (cg >= 0) ? (64'd1 << cg) : 64'd0);
    rb = a2c_lkp_rsp_id % N;
    check("bk_rsp_vld", bk_rsp_vld, a2c_lkp_rsp_vld ? (64'd1 << rb) : 64'd0);
    check("bk_rsp_id", bk_rsp_id, a2c_lkp_rsp_id >> BW);
    check("bk_rslt", bk_rslt, a2c_lkp_rslt);
    check("valid_o", table_ex_valid_o, m_vo);
    check("res_fields", {table_ex_info_o, table_ex_id_o, table_ex_so_o, table_ex_data_entry_o,
          table_ex_rob_entry_o}, {m_info, m_id, m_so, m_de, m_re});
    check("c2a_vld", c2a_lkp_vld, m_cv);
    check("c2a_fields", {c2a_lkp_info, c2a_lkp_req_id}, {m_cinfo, m_creq});
    check("rsp_err", rsp_err_o, m_err);
    if (rst) begin
      model_reset();
    end else begin
      if (rg >= 0) begin
        m_vo = 1'b1; m_rptr = rg;
        m_info = bk_out_info[rg*IL +: IL]; m_id = bk_out_id[rg*OI +: OI]; m_so = bk_out_so[rg];
        m_de = bk_out_data_entry[rg*RW +: RW]; m_re = bk_out_rob_entry[rg*OW +: OW];
      end else if (table_ex_ready_o) m_vo = 1'b0;
      if (cg >= 0) begin
        m_cv = 1'b1; m_cptr = cg;
        m_cinfo = {bk_c2a_info[cg*BIL +: BIL], BW'(cg)};
        m_creq  = {bk_c2a_req_id[cg*BRQ +: BRQ], BW'(cg)};
      end else if (a2c_lkp_rdy) m_cv = 1'b0;
      for (int b = 0; b < N; b++) begin
        bit inc, dec;
        inc = (cg == b);
        dec = a2c_lkp_rsp_vld && (rb == b);
        if (inc && !dec) m_cnt[b]++;
        else if (dec && !inc) begin
          if (m_cnt[b] == 0) m_err = 1'b1;
          else m_cnt[b]--;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic respond(input int bank);
    a2c_lkp_rsp_vld = 1'b1;
    a2c_lkp_rsp_id  = {BRQ'($urandom), BW'(bank)};
  endtask

  initial begin
    int cand [$];
    clear_inputs();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();
    rst = 1'b0;
    #1;
    check("rst_valid_o", table_ex_valid_o, 1'b0);
    check("rst_c2a_vld", c2a_lkp_vld, 1'b0);
    check("rst_err", rsp_err_o, 1'b0);
    step();

    // steering to bank 2
    table_ex_valid_i = 1'b1; table_ex_info_i = 20'hABCD2; bk_in_ready = 4'b0100;
    #1;
    check("steer_valid", bk_in_valid, 4'b0100);
    check("steer_ready", table_ex_ready_i, 1'b1);
    check("steer_info", bk_in_info, 18'h2AF34);
    bk_in_ready = 4'b1011;
    #1;
    check("steer_notready", table_ex_ready_i, 1'b0);
    step();
    table_ex_valid_i = 1'b0;

    // round robin with all banks valid from reset
    bk_out_valid = 4'hF; table_ex_ready_o = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1;
      check("rr_grant", bk_out_ready, 64'd1 << (k % 4));
      check("rr_valid_o", table_ex_valid_o, k > 0);
      step();
    end
    // backpressure: nothing granted, pointer holds
    table_ex_ready_o = 1'b0;
    for (int k = 0; k < 5; k++) begin
      rand_data();
      #1;
      check("stall_ready", bk_out_ready, 4'b0000);
      check("stall_valid", table_ex_valid_o, 1'b1);
      step();
    end
    table_ex_ready_o = 1'b1;
    #1;
    check("stall_resume", bk_out_ready, 4'b0010);
    step();
    bk_out_valid = '0;
    step(); step();

    // bank 1 throttles after MAX_OUTSTANDING misses
    bk_c2a_vld = 4'b0010; a2c_lkp_rdy = 1'b1;
    for (int k = 0; k < 10; k++) begin
      rand_data();
      #1;
      check("thr_rdy", bk_c2a_rdy, (k < MO) ? 4'b0010 : 4'b0000);
      step();
    end
    #1;
    check("c2a_tag", c2a_lkp_info[1:0], 2'd1);
    check("c2a_reqtag", c2a_lkp_req_id[1:0], 2'd1);
    respond(1);
    #1;
    check("thr_rsp_rdy", bk_c2a_rdy, 4'b0000);
    check("thr_rsp_vld", bk_rsp_vld, 4'b0010);
    step();
    a2c_lkp_rsp_vld = 1'b0;
    #1;
    check("thr_resume", bk_c2a_rdy, 4'b0010);
    step();

    // bank 2: simultaneous issue and response leaves count at 1
    bk_c2a_vld = 4'b0100;
    step();
    respond(2);
    #1;
    check("sim_rdy", bk_c2a_rdy, 4'b0100);
    step();
    bk_c2a_vld = '0;
    step();
    a2c_lkp_rsp_vld = 1'b0;
    #1;
    check("sim_noerr", rsp_err_o, 1'b0);
    respond(2);
    step();
    a2c_lkp_rsp_vld = 1'b0;
    #1;
    check("sim_err", rsp_err_o, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;

    // response to idle bank 3
    respond(3);
    step();
    a2c_lkp_rsp_vld = 1'b0;
    step(); step();
    #1;
    check("idle_err_sticky", rsp_err_o, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;

    // reset mid-operation
    bk_c2a_vld = 4'b0001; a2c_lkp_rdy = 1'b1; bk_out_valid = 4'b0100; table_ex_ready_o = 1'b0;
    repeat (3) step();
    #1;
    check("mid_vo", table_ex_valid_o, 1'b1);
    check("mid_cv", c2a_lkp_vld, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    bk_out_valid = 4'hF; bk_c2a_vld = 4'hF; table_ex_ready_o = 1'b1;
    #1;
    check("post_rst_vo", table_ex_valid_o, 1'b0);
    check("post_rst_cv", c2a_lkp_vld, 1'b0);
    check("post_rst_res_gnt", bk_out_ready, 4'b0001);
    check("post_rst_c2a_gnt", bk_c2a_rdy, 4'b0001);
    step();
    bk_out_valid = '0; bk_c2a_vld = '0;
    respond(0); step();
    a2c_lkp_rsp_vld = 1'b0;
    #1;
    check("post_rst_cnt_a", rsp_err_o, 1'b0);
    respond(0); step();
    a2c_lkp_rsp_vld = 1'b0;
    #1;
    check("post_rst_cnt_b", rsp_err_o, 1'b1);
    rst = 1'b1; step(); rst = 1'b0;

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      rand_data();
      table_ex_valid_i = 1'($urandom);
      bk_in_ready      = N'($urandom);
      bk_out_valid     = N'($urandom);
      table_ex_ready_o = ($urandom_range(0, 3) != 0);
      bk_c2a_vld       = N'($urandom);
      a2c_lkp_rdy      = ($urandom_range(0, 3) != 0);
      cand.delete();
      for (int b = 0; b < N; b++) if (m_cnt[b] > 0) cand.push_back(b);
      if (cand.size() > 0 && $urandom_range(0, 1) == 1)
        respond(cand[$urandom_range(0, cand.size() - 1)]);
      else
        a2c_lkp_rsp_vld = 1'b0;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
